bcd_to_unsigned: RTL and testbench

//  Sequential BCD-to-binary decoder; inverse of the binary-to-BCD converter used on the display path.

---
 rtl/bcd_to_unsigned_if.sv | 16 +
 rtl/bcd_to_unsigned.sv | 121 ++++++++++++
 tb/tb_bcd_to_unsigned.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_unsigned_if.sv
// Handshake bundle for bcd_to_unsigned: start/capture on the master side,
// status and result on the slave side.
interface bcd_to_unsigned_if #(
  parameter int DIGITS    = 8,
  parameter int OUT_WIDTH = 32
);
  logic                  trigger;
  logic [4*DIGITS-1:0]   bcd;
  logic                  idle;
  logic                  valid;
  logic [OUT_WIDTH-1:0]  out;
  logic                  error;

  modport master (output trigger, bcd, input idle, valid, out, error);
  modport slave  (input trigger, bcd, output idle, valid, out, error);
endinterface

// File: rtl/bcd_to_unsigned.sv
// Sequential BCD-to-binary decoder (reverse double-dabble).
// One shift-and-correct step per clock, 4*DIGITS steps per conversion.
// Optional macro BCD_CHECK_EN: reject captured digits > 9, pulsing valid with
// error=1 after two cycles and leaving out untouched. Without it, error stays 0.
module bcd_to_unsigned #(
  parameter int DIGITS    = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  bcd_to_unsigned_if.slave   bus
);
  localparam int              BW   = 4 * DIGITS;
  localparam int              CW   = $clog2(BW + 1);
  localparam logic [CW-1:0]   LAST = CW'(BW - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                r_state;
  logic [BW-1:0]         r_sr_bcd;
  logic [BW-1:0]         r_sr_bin;
  logic [CW-1:0]         r_cnt;
  logic                  r_idle;
  logic                  r_valid;
  logic                  r_error;
  logic [OUT_WIDTH-1:0]  r_out;

  logic [BW-1:0]         w_bcd_shift;
  logic [BW-1:0]         w_bcd_next;
  logic [BW-1:0]         w_bin_next;

  // One reverse double-dabble step: shift right across bcd:bin, then fix every digit >= 8.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    w_bcd_shift = r_sr_bcd >> 1;
    w_bin_next  = {r_sr_bcd[0], r_sr_bin[BW-1:1]};
    w_bcd_next  = w_bcd_shift;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_bcd_shift[4*d +: 4] >= 4'd8) begin
        w_bcd_next[4*d +: 4] = w_bcd_shift[4*d +: 4] - 4'd3;
      end
    end
  end

`ifdef BCD_CHECK_EN
  logic w_bad;
  logic r_bad;

  // Flag any input digit above 9 so the conversion can be rejected at capture.
  always_comb begin
    w_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bus.bcd[4*d +: 4] > 4'd9) w_bad = 1'b1;
    end
  end
`endif

  // Control FSM and datapath: IDLE -> SHIFT -> DONE -> IDLE, all outputs registered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state  <= S_IDLE;
      r_idle   <= 1'b1;
      r_valid  <= 1'b0;
      r_out    <= '0;
      r_error  <= 1'b0;
      r_sr_bcd <= '0;
      r_sr_bin <= '0;
      r_cnt    <= '0;
`ifdef BCD_CHECK_EN
      r_bad    <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.trigger) begin
            r_sr_bcd <= bus.bcd;
            r_sr_bin <= '0;
            r_cnt    <= '0;
            r_idle   <= 1'b0;
`ifdef BCD_CHECK_EN
            r_bad    <= w_bad;
            r_state  <= w_bad ? S_DONE : S_SHIFT;
`else
            r_state  <= S_SHIFT;
`endif
          end
        end
        S_SHIFT: begin
          r_sr_bcd <= w_bcd_next;
          r_sr_bin <= w_bin_next;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= S_DONE;
        end
        S_DONE: begin
          r_valid <= 1'b1;
          r_idle  <= 1'b1;
          r_state <= S_IDLE;
`ifdef BCD_CHECK_EN
          if (r_bad) begin
            r_error <= 1'b1;
          end else begin
            r_error <= 1'b0;
            r_out   <= OUT_WIDTH'(r_sr_bin);
          end
`else
          r_error <= 1'b0;
          r_out   <= OUT_WIDTH'(r_sr_bin);
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.idle  = r_idle;
  assign bus.valid = r_valid;
  assign bus.out   = r_out;
  assign bus.error = r_error;
endmodule

// File: tb/tb_bcd_to_unsigned.sv
// Directed self-checking bench for bcd_to_unsigned (DIGITS=8, OUT_WIDTH=32).
module tb_bcd_to_unsigned;
  localparam int DIGITS    = 8;
  localparam int OUT_WIDTH = 32;
  localparam int LAT       = 4 * DIGITS + 1;   // accept edge to valid edge
  localparam int PERIOD    = 4 * DIGITS + 2;   // trigger held high

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  bcd_to_unsigned_if #(.DIGITS(DIGITS), .OUT_WIDTH(OUT_WIDTH)) bus ();

  bcd_to_unsigned #(.DIGITS(DIGITS), .OUT_WIDTH(OUT_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Start one conversion and wait (bounded) for valid; lat = edges after accept, -1 on timeout.
  task automatic convert(input logic [31:0] v, output int lat);
    @(negedge clk);
    bus.bcd     = v;
    bus.trigger = 1'b1;
    @(posedge clk); #1;
    bus.trigger = 1'b0;
    lat = 0;
    while (bus.valid !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
      if (lat > 200) begin
        lat = -1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.trigger = 1'b0;
    bus.bcd     = '0;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b expected 1", bus.idle); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid); end
    checks++; if (bus.out !== 32'd0) begin errors++; $display("FAIL reset_out: got %h expected 0", bus.out); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", bus.error); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero();
    int lat;
    convert(32'h00000000, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (bus.out !== 32'd0) begin errors++; $display("FAIL zero_out: got %h expected 0", bus.out); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL zero_error: got %b expected 0", bus.error); end
    @(posedge clk); #1;
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL zero_idle_after: got %b expected 1", bus.idle); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL zero_valid_single: got %b expected 0", bus.valid); end
  endtask

  task automatic test_values();
    logic [31:0] vb[4];
    logic [31:0] ve[4];
    int lat;
    vb[0] = 32'h00123456; ve[0] = 32'h0001E240;   // 123456
    vb[1] = 32'h99999999; ve[1] = 32'h05F5E0FF;   // 99999999
    vb[2] = 32'h00000010; ve[2] = 32'd10;
    vb[3] = 32'h00000009; ve[3] = 32'd9;
    for (int i = 0; i < 4; i++) begin
      convert(vb[i], lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL value%0d_latency: got %0d expected %0d", i, lat, LAT); end
      checks++; if (bus.out !== ve[i]) begin errors++; $display("FAIL value%0d_out: got %h expected %h", i, bus.out, ve[i]); end
    end
    @(negedge clk);
    bus.bcd = 32'h00000003;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (bus.out !== 32'd9) begin errors++; $display("FAIL out_hold: got %h expected 9", bus.out); end
  endtask

  task automatic test_back_to_back();
    int t1, t2, n;
    @(negedge clk);
    bus.bcd     = 32'h00000001;
    bus.trigger = 1'b1;
    @(posedge clk); #1;
    bus.bcd = 32'h00235959;   // must not disturb the running job; captured by the next one
    n = 0;
    while (bus.valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    t1 = cyc;
    checks++; if (bus.out !== 32'd1) begin errors++; $display("FAIL b2b_first_out: got %h expected 1", bus.out); end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.valid !== 1'b1 && n < 200);
    t2 = cyc;
    bus.trigger = 1'b0;
    checks++; if (t2 - t1 !== PERIOD) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", t2 - t1, PERIOD); end
    checks++; if (bus.out !== 32'd235959) begin errors++; $display("FAIL b2b_second_out: got %0d expected 235959", bus.out); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL b2b_idle_after: got %b expected 1", bus.idle); end
  endtask

  task automatic test_abort();
    int nvalid;
    @(negedge clk);
    bus.bcd     = 32'h00000555;
    bus.trigger = 1'b1;
    @(posedge clk); #1;
    bus.trigger = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL abort_idle: got %b expected 1", bus.idle); end
    checks++; if (bus.out !== 32'd0) begin errors++; $display("FAIL abort_out: got %h expected 0", bus.out); end
    @(negedge clk);
    rst = 1'b0;
    nvalid = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.valid === 1'b1) nvalid++; end
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses expected 0", nvalid); end

    // Trigger pulses while busy must be dropped: one job, one result.
    @(negedge clk);
    bus.bcd     = 32'h00000077;
    bus.trigger = 1'b1;
    @(posedge clk); #1;
    nvalid = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      bus.bcd     = 32'h00000011;
      bus.trigger = (i >= 5 && i <= 8) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      if (bus.valid === 1'b1) nvalid++;
    end
    checks++; if (nvalid !== 1) begin errors++; $display("FAIL busy_trigger_pulses: got %0d expected 1", nvalid); end
    checks++; if (bus.out !== 32'd77) begin errors++; $display("FAIL busy_trigger_out: got %0d expected 77", bus.out); end
  endtask

  task automatic test_error_flag();
    int lat;
    convert(32'h00000042, lat);
    checks++; if (bus.out !== 32'd42) begin errors++; $display("FAIL err_prior_out: got %0d expected 42", bus.out); end
    convert(32'h000000A0, lat);
`ifdef BCD_CHECK_EN
    // Accept edge enters DONE directly; the next edge raises valid.
    checks++; if (lat !== 1) begin errors++; $display("FAIL err_latency: got %0d expected 1", lat); end
    checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL err_flag: got %b expected 1", bus.error); end
    checks++; if (bus.out !== 32'd42) begin errors++; $display("FAIL err_out_kept: got %0d expected 42", bus.out); end
`else
    checks++; if (lat !== LAT) begin errors++; $display("FAIL err_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL err_flag: got %b expected 0", bus.error); end
`endif
    convert(32'h00000007, lat);
    checks++; if (lat !== LAT) begin errors++; $display("FAIL err_clear_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL err_clear_flag: got %b expected 0", bus.error); end
    checks++; if (bus.out !== 32'd7) begin errors++; $display("FAIL err_clear_out: got %0d expected 7", bus.out); end
  endtask

  initial begin
    bus.trigger = 1'b0;
    bus.bcd     = '0;
    test_reset();
    test_zero();
    test_values();
    test_back_to_back();
    test_abort();
    test_error_flag();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
